// File: rtl/omap_writeback_seq.sv
// Write-back sequencer: snapshots the omap, walks entries 1..NUM_PE and does a
// read-modify-write of each PE column result into the output BRAMs. Optional: WB_SATURATE_EN.
module omap_writeback_seq #(
  parameter int unsigned NUM_PE = 16,
  parameter int unsigned DW     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               acc_en,
  input  logic [NUM_PE*DW-1:0] pe_result_flat,
  output logic               omap_load,
  output logic [4:0]         done,
  input  logic [3:0]         bram_sel,
  input  logic [9:0]         bram_addr,
  output logic [3:0]         wb_sel,
  output logic [9:0]         wb_addr,
  output logic               wb_rd_en,
  input  logic [DW-1:0]      wb_rdata,
  output logic               wb_wr_en,
  output logic [DW-1:0]      wb_wdata,
  output logic               busy,
  output logic               tile_done
);

  localparam int unsigned IW = $clog2(NUM_PE);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, WRITE, FIN} state_t;

  state_t        state, state_nxt;
  logic [4:0]    k, k_nxt;
  logic          acc_q;
  logic [DW-1:0] pe_q [NUM_PE];

  logic          entry_invalid;
  logic          last;
  logic [DW-1:0] pe_sel;
  logic [DW:0]   sum_ext;
  logic [DW-1:0] sum_val;

  logic          omap_load_nxt, rd_nxt, wr_nxt, busy_nxt, tile_done_nxt;
  logic [4:0]    done_nxt;
  logic [3:0]    sel_nxt;
  logic [9:0]    addr_nxt;
  logic [DW-1:0] wdata_nxt;

  assign entry_invalid = ({bram_sel, bram_addr} == 14'h3FFF);
  assign last          = (k == 5'(NUM_PE));
  assign pe_sel        = pe_q[IW'(k - 5'd1)];

  // State, entry counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= 5'd0;
      acc_q     <= 1'b0;
      omap_load <= 1'b0;
      done      <= 5'd0;
      wb_sel    <= 4'd0;
      wb_addr   <= 10'd0;
      wb_rd_en  <= 1'b0;
      wb_wr_en  <= 1'b0;
      wb_wdata  <= '0;
      busy      <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      omap_load <= omap_load_nxt;
      done      <= done_nxt;
      wb_sel    <= sel_nxt;
      wb_addr   <= addr_nxt;
      wb_rd_en  <= rd_nxt;
      wb_wr_en  <= wr_nxt;
      wb_wdata  <= wdata_nxt;
      busy      <= busy_nxt;
      tile_done <= tile_done_nxt;
      if (state == IDLE && start) begin
        acc_q <= acc_en;
        for (int i = 0; i < NUM_PE; i++) pe_q[i] <= pe_result_flat[i*DW +: DW];
      end
    end
  end

  // Next-state and entry counter
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  begin
        state_nxt = ISSUE;
        k_nxt     = 5'd1;
      end
      ISSUE: begin
        if (entry_invalid) begin
          if (last) state_nxt = FIN;
          else      k_nxt     = k + 5'd1;
        end else if (acc_q) begin
          state_nxt = WAIT;
        end else begin
          state_nxt = WRITE;
        end
      end
      WAIT:  state_nxt = WRITE;
      WRITE: begin
        if (last) begin
          state_nxt = FIN;
        end else begin
          state_nxt = ISSUE;
          k_nxt     = k + 5'd1;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes land one cycle after their decision
  always_comb begin
    omap_load_nxt = (state_nxt == LOAD);
    busy_nxt      = (state_nxt inside {LOAD, ISSUE, WAIT, WRITE});
    tile_done_nxt = (state_nxt == FIN);
    done_nxt      = (state_nxt inside {ISSUE, WAIT, WRITE}) ? k_nxt : 5'd0;
    sel_nxt       = wb_sel;
    addr_nxt      = wb_addr;
    rd_nxt        = 1'b0;
    wr_nxt        = 1'b0;
    wdata_nxt     = wb_wdata;
    sum_ext       = {wb_rdata[DW-1], wb_rdata} + {pe_sel[DW-1], pe_sel};
`ifdef WB_SATURATE_EN
    if (sum_ext[DW] != sum_ext[DW-1])
      sum_val = sum_ext[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      sum_val = sum_ext[DW-1:0];
`else
    sum_val = sum_ext[DW-1:0];
`endif
    if (state == ISSUE) begin
      sel_nxt  = bram_sel;
      addr_nxt = bram_addr;
      rd_nxt   = !entry_invalid && acc_q;
    end
    if (state == WRITE) begin
      wr_nxt    = 1'b1;
      wdata_nxt = acc_q ? sum_val : pe_sel;
    end
  end

endmodule

// File: tb/tb_omap_writeback_seq.sv
// Scoreboard bench for omap_writeback_seq with omap-buffer and output-BRAM models.
module tb_omap_writeback_seq;

  typedef struct packed {
    logic [3:0]  sel;
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         rst, start, acc_en;
  logic [255:0] pe_result_flat;
  logic         omap_load;
  logic [4:0]   done;
  logic [3:0]   bram_sel;
  logic [9:0]   bram_addr;
  logic [3:0]   wb_sel;
  logic [9:0]   wb_addr;
  logic         wb_rd_en;
  logic [15:0]  wb_rdata;
  logic         wb_wr_en;
  logic [15:0]  wb_wdata;
  logic         busy, tile_done;

  logic [15:0]  pe_v [16];
  logic [13:0]  omap_tbl [16];
  logic [13:0]  omap_snap [16];
  logic [15:0]  mem [16][1024];
  logic         pl_en;
  logic [3:0]   pl_sel;
  logic [9:0]   pl_addr;
  logic [15:0]  pl_data;

  int  cyc = 0;
  int  tstart = 0;
  int  errors = 0;
  int  checks = 0;
  int  rd_cnt = 0;
  int  wr_cnt = 0;
  int  td_cnt = 0;
  wr_t exp_wr[$];
  int  exp_td[$];

  omap_writeback_seq dut (
    .clk(clk), .rst(rst), .start(start), .acc_en(acc_en),
    .pe_result_flat(pe_result_flat), .omap_load(omap_load), .done(done),
    .bram_sel(bram_sel), .bram_addr(bram_addr), .wb_sel(wb_sel), .wb_addr(wb_addr),
    .wb_rd_en(wb_rd_en), .wb_rdata(wb_rdata), .wb_wr_en(wb_wr_en), .wb_wdata(wb_wdata),
    .busy(busy), .tile_done(tile_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < 16; i++) pe_result_flat[i*16 +: 16] = pe_v[i];
  end

  // Omap buffer: snapshot on load, target looked up combinationally from done
  always @(posedge clk) begin
    if (omap_load) for (int i = 0; i < 16; i++) omap_snap[i] <= omap_tbl[i];
  end
  assign {bram_sel, bram_addr} = (done == 5'd0) ? 14'h3FFF : omap_snap[4'(done - 5'd1)];

  // Output BRAM banks, 1-cycle read latency
  always @(posedge clk) begin
    if (pl_en)    mem[pl_sel][pl_addr] <= pl_data;
    if (wb_wr_en) mem[wb_sel][wb_addr] <= wb_wdata;
    if (wb_rd_en) wb_rdata <= mem[wb_sel][wb_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pop expectations whenever the DUT writes or finishes a tile
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (wb_rd_en) rd_cnt++;
      if (wb_wr_en) begin
        wr_cnt++;
        if (exp_wr.size() == 0) begin
          check("wb_write_unexpected", 1, 0);
        end else begin
          e = exp_wr.pop_front();
          checks++;
          if ({wb_sel, wb_addr, wb_wdata} != e) begin
            errors++;
            $display("FAIL wb_write: got sel=%0d addr=%0d data=%0d expected sel=%0d addr=%0d data=%0d",
                     wb_sel, wb_addr, $signed(wb_wdata), e.sel, e.addr, $signed(e.data));
          end
        end
      end
      if (tile_done) begin
        td_cnt++;
        if (exp_td.size() == 0) check("tile_done_unexpected", 1, 0);
        else check("tile_latency", cyc - tstart, exp_td.pop_front());
      end
    end
  end

  task automatic poke(input logic [3:0] s, input logic [9:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_sel = s; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic launch(input logic acc);
    @(posedge clk); #1;
    start  = 1'b1;
    acc_en = acc;
    tstart = cyc;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300 && exp_td.size() != 0; i++) @(negedge clk);
    if (exp_td.size() != 0) begin
      check({name, "_timeout"}, exp_td.size(), 0);
      exp_td.delete();
    end
    repeat (3) @(negedge clk);
    check({name, "_writes_missing"}, exp_wr.size(), 0);
    exp_wr.delete();
  endtask

  task automatic clear_map();
    for (int i = 0; i < 16; i++) omap_tbl[i] = 14'h3FFF;
  endtask

  initial begin
    int rd0, wr0, td0;
    rst = 1'b1; start = 1'b0; acc_en = 1'b0; pl_en = 1'b0;
    pl_sel = '0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 16; i++) pe_v[i] = '0;
    clear_map();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", int'({omap_load, done, wb_rd_en, wb_wr_en, busy, tile_done}), 0);
    check("reset_wb", int'({wb_sel, wb_addr, wb_wdata}), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Overwrite all 16 entries
    for (int i = 0; i < 16; i++) begin
      omap_tbl[i] = {4'(i), 10'(i*4)};
      pe_v[i]     = 16'(i + 1);
      exp_wr.push_back('{sel: 4'(i), addr: 10'(i*4), data: 16'(i + 1)});
    end
    exp_td.push_back(34);
    launch(1'b0);
    wait_idle("overwrite");
    check("overwrite_bank5", int'(mem[5][20]), 6);
    check("overwrite_bank15", int'(mem[15][60]), 16);

    // Reset during WAIT of done=5: entries 0..3 complete, entry 4 dropped
    for (int i = 0; i < 4; i++)
      exp_wr.push_back('{sel: 4'(i), addr: 10'(i*4), data: 16'(2*(i + 1))});
    launch(1'b1);
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_at_done", int'(done), 5);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_ctrl", int'({omap_load, done, wb_rd_en, wb_wr_en, busy, tile_done}), 0);
    check("midrst_wb", int'({wb_sel, wb_addr, wb_wdata}), 0);
    repeat (5) @(negedge clk);
    check("midrst_writes", exp_wr.size(), 0);
    check("midrst_entry4", int'(mem[4][16]), 5);
    exp_wr.delete();
    for (int i = 0; i < 16; i++)
      exp_wr.push_back('{sel: 4'(i), addr: 10'(i*4), data: (i < 4) ? 16'(3*(i + 1)) : 16'(2*(i + 1))});
    exp_td.push_back(50);
    launch(1'b1);
    wait_idle("after_rst");

    // Entries 3 and 7 share bank 2 / addr 5
    clear_map();
    omap_tbl[3] = {4'd2, 10'd5};
    omap_tbl[7] = {4'd2, 10'd5};
    poke(4'd2, 10'd5, 16'd10);
    pe_v[3] = 16'd4;
    pe_v[7] = 16'd6;
    exp_wr.push_back('{sel: 4'd2, addr: 10'd5, data: 16'd14});
    exp_wr.push_back('{sel: 4'd2, addr: 10'd5, data: 16'd20});
    exp_td.push_back(22);
    launch(1'b1);
    wait_idle("alias37");
    check("alias37_final", int'(mem[2][5]), 20);

    // Back-to-back entries on the same address
    clear_map();
    omap_tbl[0] = {4'd1, 10'd9};
    omap_tbl[1] = {4'd1, 10'd9};
    poke(4'd1, 10'd9, 16'd100);
    pe_v[0] = -16'sd5;
    pe_v[1] = 16'd7;
    exp_wr.push_back('{sel: 4'd1, addr: 10'd9, data: 16'd95});
    exp_wr.push_back('{sel: 4'd1, addr: 10'd9, data: 16'd102});
    exp_td.push_back(22);
    launch(1'b1);
    wait_idle("alias01");
    check("alias01_final", int'(mem[1][9]), 102);

    // Overflow in both directions
    clear_map();
    omap_tbl[0] = {4'd0, 10'd0};
    omap_tbl[1] = {4'd0, 10'd1};
    poke(4'd0, 10'd0, 16'd32000);
    poke(4'd0, 10'd1, -16'sd32000);
    pe_v[0] = 16'd1000;
    pe_v[1] = -16'sd1000;
`ifdef WB_SATURATE_EN
    exp_wr.push_back('{sel: 4'd0, addr: 10'd0, data: 16'sd32767});
    exp_wr.push_back('{sel: 4'd0, addr: 10'd1, data: -16'sd32768});
`else
    exp_wr.push_back('{sel: 4'd0, addr: 10'd0, data: -16'sd32536});
    exp_wr.push_back('{sel: 4'd0, addr: 10'd1, data: 16'sd32536});
`endif
    exp_td.push_back(22);
    launch(1'b1);
    wait_idle("overflow");

    // All entries invalid: done walks 1..16 with no strobes
    clear_map();
    rd0 = rd_cnt; wr0 = wr_cnt;
    exp_td.push_back(18);
    launch(1'b1);
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      if (n >= 2) check($sformatf("invalid_done_c%0d", n), int'(done), n - 1);
    end
    wait_idle("invalid");
    check("invalid_rd_strobes", rd_cnt - rd0, 0);
    check("invalid_wr_strobes", wr_cnt - wr0, 0);

    // start while busy and during FIN is ignored
    td0 = td_cnt;
    exp_td.push_back(18);
    launch(1'b0);
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #1 start = 1'b1;
    check("fin_tile_done", int'(tile_done), 1);
    @(posedge clk); #1 start = 1'b0;
    repeat (40) @(negedge clk);
    check("busy_start_idle", int'(busy), 0);
    wait_idle("busy_start");
    check("busy_start_tiles", td_cnt - td0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
